fir_mac_seq: RTL and testbench

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/filtro_pkg.sv | 21 ++
 rtl/fir_mac_seq_if.sv | 26 ++
 rtl/mult_signed.sv | 20 ++
 rtl/fir_mac_seq.sv | 128 ++++++++++++
 tb/tb_fir_mac_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/filtro_pkg.sv
// Shared constants and FSM encoding for the sequential FIR MAC filter.
// Width constants here describe the default build. The top derives its own widths from its
// parameters, so an overridden instance stays self-consistent.
package filtro_pkg;

    localparam int unsigned CANT_BITS = 25;
    localparam int unsigned N_TAPS    = 5;
    localparam int unsigned SUM_W     = 2 * CANT_BITS - 1;
    localparam int unsigned ACC_W     = SUM_W + $clog2(N_TAPS);
    localparam int unsigned ADDR_W    = 4;

    localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMac  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/fir_mac_seq_if.sv
// Sample/coefficient/result bus of the sequential FIR filter.
// The master side drives samples and coefficient writes. The slave side is the filter.
interface fir_mac_seq_if #(
    parameter int unsigned CANT_BITS = 25
);

    logic                        in_valid;
    logic                        in_ready;
    logic signed [CANT_BITS-1:0] in_sample;
    logic                        coef_we;
    logic [3:0]                  coef_addr;
    logic signed [CANT_BITS-1:0] coef_data;
    logic signed [2*CANT_BITS-2:0] out_sum;
    logic                        out_valid;

    modport master (
        output in_valid, in_sample, coef_we, coef_addr, coef_data,
        input  in_ready, out_sum, out_valid
    );

    modport slave (
        input  in_valid, in_sample, coef_we, coef_addr, coef_data,
        output in_ready, out_sum, out_valid
    );

endinterface

// File: rtl/mult_signed.sv
// Signed CANT_BITS x CANT_BITS multiplier, result kept to 2*CANT_BITS-1 bits.
module mult_signed #(
    parameter int unsigned CANT_BITS = 25
) (
    input  logic signed [CANT_BITS-1:0]   a,
    input  logic signed [CANT_BITS-1:0]   b,
    output logic signed [2*CANT_BITS-2:0] p
);

    localparam int unsigned PW = 2 * CANT_BITS - 1;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;

    // Widen both operands first so the multiply is evaluated at the result width.
    assign a_ext = {{(CANT_BITS - 1){a[CANT_BITS-1]}}, a};
    assign b_ext = {{(CANT_BITS - 1){b[CANT_BITS-1]}}, b};
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: one shared multiplier walks the taps, then saturates the sum.
// One sample every N_TAPS+2 cycles. Coefficients are writable only while idle.
module fir_mac_seq #(
    parameter int unsigned CANT_BITS = filtro_pkg::CANT_BITS,
    parameter int unsigned N_TAPS    = filtro_pkg::N_TAPS
) (
    input logic           clk,
    input logic           rst,
    fir_mac_seq_if.slave  bus
);

    import filtro_pkg::*;

    localparam int unsigned SW = 2 * CANT_BITS - 1;
    localparam int unsigned AW = SW + $clog2(N_TAPS);
    localparam int unsigned KW = $clog2(N_TAPS);

    localparam logic signed [SW-1:0] LIM_MAX = {1'b0, {(SW - 1){1'b1}}};
    localparam logic signed [SW-1:0] LIM_MIN = {1'b1, {(SW - 1){1'b0}}};
    localparam logic signed [AW-1:0] ACC_MAX = {{(AW - SW + 1){1'b0}}, {(SW - 1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(AW - SW + 1){1'b1}}, {(SW - 1){1'b0}}};
    localparam logic [KW-1:0]        LAST_TAP = KW'(N_TAPS - 1);

    state_t state_q, state_d;

    logic signed [CANT_BITS-1:0] x_q    [N_TAPS];
    logic signed [CANT_BITS-1:0] coef_q [N_TAPS];
    logic signed [AW-1:0]        acc_q;
    logic [KW-1:0]               k_q;
    logic signed [SW-1:0]        out_sum_q;
    logic                        out_valid_q;

    logic signed [CANT_BITS-1:0] mul_a;
    logic signed [CANT_BITS-1:0] mul_b;
    logic signed [SW-1:0]        prod;
    logic signed [AW-1:0]        prod_ext;
    logic signed [SW-1:0]        sum_sat;
    logic                        accept;
    logic                        coef_commit;

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_valid = out_valid_q;

    assign accept      = bus.in_valid && bus.in_ready;
    assign coef_commit = bus.coef_we && (state_q == StIdle) &&
                         ({1'b0, bus.coef_addr} < 5'(N_TAPS));

    assign mul_a    = x_q[k_q];
    assign mul_b    = coef_q[k_q];
    assign prod_ext = {{(AW - SW){prod[SW-1]}}, prod};

    mult_signed #(
        .CANT_BITS (CANT_BITS)
    ) u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    always_comb begin
        sum_sat = acc_q[SW-1:0];
        if (acc_q >= ACC_MAX) begin
            sum_sat = LIM_MAX;
        end else if (acc_q <= ACC_MIN) begin
            sum_sat = LIM_MIN;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StMac;
            StMac:  if (k_q == LAST_TAP) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
            acc_q       <= '0;
            k_q         <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            // Committed at the acceptance edge too, so tap 0 of that sample sees the new value.
            if (coef_commit) begin
                coef_q[bus.coef_addr[KW-1:0]] <= bus.coef_data;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        for (int i = N_TAPS - 1; i > 0; i--) begin
                            x_q[i] <= x_q[i-1];
                        end
                        x_q[0] <= bus.in_sample;
                        acc_q  <= '0;
                        k_q    <= '0;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + prod_ext;
                    k_q   <= k_q + 1'b1;
                end
                StDone: begin
                    out_sum_q   <= sum_sat;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Randomised and directed bench for fir_mac_seq against an array-based FIR reference model.
module tb_fir_mac_seq;

    localparam int NT = 5;
    localparam longint SMAX = (longint'(1) << 48) - 1;
    localparam longint SMIN = -(longint'(1) << 48);

    logic clk = 1'b0;
    logic rst = 1'b1;

    fir_mac_seq_if #(.CANT_BITS(25)) bus ();

    fir_mac_seq #(
        .CANT_BITS (25),
        .N_TAPS    (NT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    longint m_x[NT];
    longint m_c[NT];

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sx25(input logic [24:0] v);
        return longint'(signed'(v));
    endfunction

    function automatic longint model_out();
        longint acc = 0;
        for (int i = 0; i < NT; i++) acc += m_x[i] * m_c[i];
        if (acc > SMAX) acc = SMAX;
        else if (acc < SMIN) acc = SMIN;
        return acc;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_x[i] = 0;
            m_c[i] = 0;
        end
    endtask

    task automatic write_coef(input int addr, input longint data);
        logic [24:0] d;
        d = data[24:0];
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'(addr);
        bus.coef_data = d;
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        if (addr < NT) m_c[addr] = sx25(d);
    endtask

    // Offers one sample, optionally with a coincident coefficient write, a write during MAC,
    // or in_valid held through the busy window; checks result, pulse count, latency, ready.
    task automatic send(input string tag, input longint s, input bit hold, input bit cw,
                        input int cw_addr, input longint cw_data, input bit mac_wr);
        logic [24:0] sv;
        logic [24:0] cd;
        longint exp, got;
        int lat, pulses, rdy_low;
        sv = s[24:0];
        cd = cw_data[24:0];
        check_val({tag, "_ready_pre"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_sample = sv;
        if (cw) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 4'(cw_addr);
            bus.coef_data = cd;
        end
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        if (cw && cw_addr < NT) m_c[cw_addr] = sx25(cd);
        for (int i = NT - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = sx25(sv);
        exp = model_out();
        bus.in_valid = hold;
        if (hold) bus.in_sample = sv ^ 25'h0abcde;
        lat = -1; pulses = 0; rdy_low = 0; got = 0;
        for (int j = 0; j < 10; j++) begin
            if (j <= NT && !bus.in_ready) rdy_low++;
            if (bus.out_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = j;
                    got = bus.out_sum;
                end
            end
            if (j == 1 && mac_wr) begin
                bus.coef_we   = 1'b1;
                bus.coef_addr = 4'd0;
                bus.coef_data = 25'd12345;
            end
            if (j == 2) bus.coef_we = 1'b0;
            if (j == NT + 1) bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        check_val({tag, "_sum"}, got, exp);
        check_val({tag, "_pulses"}, 64'(pulses), 64'd1);
        check_val({tag, "_lat"}, 64'(lat), 64'(NT + 1));
        check_val({tag, "_rdy_low"}, 64'(rdy_low), 64'(NT + 1));
    endtask

    task automatic send_plain(input string tag, input longint s);
        send(tag, s, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        logic [24:0] r;
        longint rs;
        int pulses;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        model_reset();

        // Reset behaviour
        #12;
        check_val("rst_ready", 64'(bus.in_ready), 64'd0);
        check_val("rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_sum", bus.out_sum, 64'sd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_val("rel_ready", 64'(bus.in_ready), 64'd1);
        check_val("rel_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;

        // Impulse response
        for (int i = 0; i < NT; i++) write_coef(i, i + 1);
        send_plain("imp0", 1);
        for (int i = 1; i <= NT; i++) send_plain($sformatf("imp%0d", i), 0);

        // Handshake: in_valid held through the busy window must not be taken
        send("hold", 3, 1'b1, 1'b0, 0, 0, 1'b0);
        send_plain("after_hold", 0);

        // Saturation
        for (int i = 0; i < NT; i++) write_coef(i, 16777215);
        for (int i = 0; i < NT; i++) send_plain($sformatf("satp%0d", i), 16777215);
        for (int i = 0; i < NT; i++) send_plain($sformatf("satn%0d", i), -16777216);
        check_val("sat_min_final", bus.out_sum, 64'(SMIN));

        // Coefficient write rules
        for (int i = 0; i < NT; i++) write_coef(i, i + 1);
        write_coef(7, 999);
        for (int i = 0; i < NT; i++) send_plain($sformatf("flush%0d", i), 0);
        send("macwr", 1, 1'b0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < NT; i++) send_plain($sformatf("flushb%0d", i), 0);
        send("coinc", 2, 1'b0, 1'b1, 0, 9, 1'b0);
        check_val("coinc_18", bus.out_sum, 64'sd18);

        // Randomised traffic
        for (int n = 0; n < 30; n++) begin
            r  = 25'($urandom);
            rs = sx25(r);
            if (rs == -16777216) rs = -16777215;
            send($sformatf("rnd%0d", n), rs, 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                 longint'($urandom), 1'($urandom_range(0, 4) == 0));
        end

        // Reset in the middle of a computation
        bus.in_valid  = 1'b1;
        bus.in_sample = 25'd77;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check_val("mid_rst_sum", bus.out_sum, 64'sd0);
        check_val("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            if (bus.out_valid) pulses++;
            @(posedge clk); #1;
        end
        check_val("mid_rst_nopulse", 64'(pulses), 64'd0);
        write_coef(NT - 1, 1);
        send_plain("zero_line", 0);
        send_plain("zero_coef", 1);
        for (int i = 0; i < NT; i++) write_coef(i, i + 1);
        for (int i = 0; i < NT; i++) send_plain($sformatf("flushc%0d", i), 0);
        send_plain("reimp0", 1);
        for (int i = 1; i <= NT; i++) send_plain($sformatf("reimp%0d", i), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
